// File: rtl/led_pkg.sv
// Shared defaults and helpers for the LED fade/PWM block.
// Defaults match the board build; each module can override them by parameter.
// cnt_width gives a counter width that is still legal for a modulus of 1.
package led_pkg;

  localparam int DEF_N_LEDS     = 8;
  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_FADE_TICKS = 250;
  localparam int DEF_FADE_STEP  = 4;

  // Full-brightness code for the default resolution.
  localparam int PWM_MAX = (2 ** DEF_PWM_BITS) - 1;

  // Width of a counter running 0..n-1; at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness register, saturating ramp toward target, PWM compare.
// led is registered one cycle after bright; at_target is combinational from bright_next.
// No backpressure: a step is applied whenever step_tick is seen with fade_en high.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int FADE_STEP = DEF_FADE_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_on,
  input  logic                step_tick,
  input  logic                fade_en,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP = (PWM_BITS + 1)'(FADE_STEP);

  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] bright_next;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS:0]   sum;

  assign target = target_on ? MAX : '0;
  // One extra bit so the upward step can be checked for overshoot past MAX.
  assign sum    = {1'b0, bright} + STEP;

  // Next brightness: jump in bypass mode, otherwise one saturating step per tick.
  always_comb begin
    bright_next = bright;
    if (!fade_en) begin
      bright_next = target;
    end else if (step_tick) begin
      if (bright < target) begin
        bright_next = (sum > {1'b0, MAX}) ? MAX : sum[PWM_BITS-1:0];
      end else if (bright > target) begin
        bright_next = ({1'b0, bright} < STEP) ? '0 : (bright - STEP[PWM_BITS-1:0]);
      end
    end
  end

  assign at_target = (bright_next == target);

  // Brightness state and PWM pin drive; pwm_cnt never reaches MAX so MAX is solid on.
  always_ff @(posedge clk) begin
    if (reset) begin
      bright <= '0;
      led    <= 1'b0;
    end else begin
      bright <= bright_next;
      led    <= (pwm_cnt < bright);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED fader: registers the pattern, shares one prescaler and PWM counter across channels.
// Pattern to target is 1 cycle; pin drive lags brightness by 1 cycle; busy is registered.
// No backpressure: pattern_in is sampled every cycle and never stalled.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS     = DEF_N_LEDS,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int FADE_TICKS = DEF_FADE_TICKS,
  parameter int FADE_STEP  = DEF_FADE_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] pattern_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] leds_out,
  output logic              busy
);

  localparam int                  PS_W     = cnt_width(FADE_TICKS);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(FADE_TICKS - 1);
  // PWM period is MAX cycles (0..MAX-1) so that bright == MAX stays fully on.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [N_LEDS-1:0]   pattern_r;
  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LEDS-1:0]   at_target;
  logic                step_tick;

  assign step_tick = (prescaler == PS_LAST);

  // Input register and shared free-running counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= '0;
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      pattern_r <= pattern_in;
      prescaler <= step_tick ? '0 : (prescaler + 1'b1);
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : (pwm_cnt + 1'b1);
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .target_on(pattern_r[i]),
      .step_tick(step_tick),
      .fade_en  (fade_en),
      .pwm_cnt  (pwm_cnt),
      .led      (leds_out[i]),
      .at_target(at_target[i])
    );
  end

  // busy tracks the value bright takes this cycle, so it drops on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= ~&at_target;
    end
  end

endmodule
